// File: rtl/gec_pkg.sv
// Shared types and constants for gated_event_counter and its gate timer.
package gec_pkg;

    typedef enum logic {
        GEC_IDLE  = 1'b0,
        GEC_COUNT = 1'b1
    } gec_state_t;

    localparam logic GEC_MODE_SINGLE = 1'b0;
    localparam logic GEC_MODE_CONT   = 1'b1;

endpackage

// File: rtl/gec_window_timer.sv
// Gate window timer: counts enabled cycles and flags the last cycle of each window.
module gec_window_timer #(
    parameter int GATE_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_o
);

    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

    logic [TW-1:0] timer;

    // The timer wraps itself on the last cycle, so back-to-back windows need no clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (en) begin
            timer <= (timer == LAST) ? '0 : timer + 1'b1;
        end
    end

    assign last_o = en && (timer == LAST);

endmodule

// File: rtl/gated_event_counter.sv
// Gated event counter with valid/ready result hand-off; GEC_SATURATE_EN selects clamp vs wrap.
module gated_event_counter
    import gec_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int GATE_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic             event_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] count_o,
    output logic             valid_o,
    output logic             overrun_o,
    output logic             sat_o,
    output logic             busy_o
);

    gec_state_t       state, state_next;
    logic             mode_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_inc;
    logic             start_win, capture, counting, last;

    assign counting = (state == GEC_COUNT) && !stop_i;
    assign busy_o   = (state == GEC_COUNT);

    gec_window_timer #(.GATE_CYCLES(GATE_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_win),
        .en     (counting),
        .last_o (last)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        start_win  = 1'b0;
        capture    = 1'b0;
        case (state)
            GEC_IDLE: begin
                if (start_i && !stop_i) begin
                    state_next = GEC_COUNT;
                    start_win  = 1'b1;
                end
            end
            GEC_COUNT: begin
                if (stop_i) begin
                    state_next = GEC_IDLE;
                end else if (last) begin
                    capture = 1'b1;
                    if (mode_q != GEC_MODE_CONT) state_next = GEC_IDLE;
                end
            end
            default: state_next = GEC_IDLE;
        endcase
    end

`ifdef GEC_SATURATE_EN
    localparam logic [WIDTH-1:0] ACC_MAX = '1;
    logic acc_clip, win_clip;

    assign acc_clip = event_i && (acc == ACC_MAX);
    assign acc_inc  = acc_clip ? acc : acc + WIDTH'(event_i);

    // win_clip remembers a clamp earlier in the window; the last cycle's own clamp is OR-ed at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_clip <= 1'b0;
            sat_o    <= 1'b0;
        end else begin
            if (start_win || capture) win_clip <= 1'b0;
            else if (counting)        win_clip <= win_clip | acc_clip;
            if (capture)              sat_o    <= win_clip | acc_clip;
        end
    end
`else
    assign acc_inc = acc + WIDTH'(event_i);
    assign sat_o   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GEC_IDLE;
            mode_q    <= GEC_MODE_SINGLE;
            acc       <= '0;
            count_o   <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state <= state_next;
            if (start_win) mode_q <= mode_i;
            if (start_win || capture) acc <= '0;
            else if (counting)        acc <= acc_inc;
            if (capture) count_o <= acc_inc;
            valid_o   <= capture | (valid_o & ~ready_i);
            overrun_o <= (capture & valid_o & ~ready_i) | (overrun_o & ~(valid_o & ready_i));
        end
    end

endmodule
